// File: rtl/endec_host_adapter_pkg.sv
// Shared types and word-count constants for the encoder/decoder host adapter.
// Frame widths are fixed by the core: 128 b encoder input, up to 384 b decoder input.
package endec_host_adapter_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

  localparam int WORD_W    = 32;
  localparam int FRAME_W   = 384;
  localparam int MAX_WORDS = 12;

  localparam logic [3:0] ENC_IN_WORDS  = 4'd4;
  localparam logic [3:0] DEC_OUT_WORDS = 4'd4;
  localparam logic [3:0] R12_WORDS     = 4'd8;
  localparam logic [3:0] R13_WORDS     = 4'd12;

  function automatic logic [3:0] rate_words(input logic code_rate);
    return code_rate ? R13_WORDS : R12_WORDS;
  endfunction

  // The coded side of the core carries 8 or 12 words; the plain side always 4.
  function automatic logic [3:0] in_words(input logic mode, input logic code_rate);
    return mode ? rate_words(code_rate) : ENC_IN_WORDS;
  endfunction

  function automatic logic [3:0] out_words(input logic mode, input logic code_rate);
    return mode ? DEC_OUT_WORDS : rate_words(code_rate);
  endfunction

endpackage

// File: rtl/endec_word_shifter.sv
// 384-bit frame register: bulk load, or write one 32-bit word by index; combinational word read by index.
// One-cycle write latency, no flow control (the owner gates load_en/wr_en).
module endec_word_shifter
  import endec_host_adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               wr_en,
  input  logic [3:0]         wr_idx,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [3:0]         rd_idx,
  output logic [FRAME_W-1:0] q,
  output logic [WORD_W-1:0]  rd_word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_data;
    end else if (wr_en) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (wr_idx == 4'(k)) q[k*WORD_W +: WORD_W] <= wr_word;
      end
    end
  end

  // Indices past the last word read as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (rd_idx == 4'(k)) rd_word = q[k*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/endec_host_adapter.sv
// Host stream front end: gathers 32-bit words into a core frame, runs the core, streams the result back.
// Latency: last word in -> o_en 1 cycle, done -> first o_m_valid 1 cycle; output stalls indefinitely on i_m_ready=0.
module endec_host_adapter
  import endec_host_adapter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         i_code_rate,
  input  logic         i_constr_len,
  input  logic         i_mode_sel,
  input  logic [31:0]  i_s_data,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  output logic [31:0]  o_m_data,
  output logic         o_m_valid,
  input  logic         i_m_ready,
  output logic         o_en,
  output logic         o_code_rate,
  output logic         o_constr_len,
  output logic         o_mode_sel,
  output logic [127:0] o_encoder_data_frame,
  output logic [383:0] o_decoder_data_frame,
  input  logic [383:0] i_encoder_data,
  input  logic         i_encoder_done,
  input  logic [127:0] i_decoder_data,
  input  logic         i_decoder_done,
  output logic         o_busy,
  output logic         o_timeout
);

  state_t             state;
  logic [3:0]         cnt;
  logic [CNT_W-1:0]   tmr;
  logic               s_fire, m_fire, done_hit;
  logic [3:0]         need_in, need_out;
  logic [FRAME_W-1:0] in_q, result, unused_out_q;
  logic [WORD_W-1:0]  out_word, unused_in_word;

  assign s_fire   = o_s_ready & i_s_valid;
  assign m_fire   = o_m_valid & i_m_ready;
  assign done_hit = o_mode_sel ? i_decoder_done : i_encoder_done;
  assign result   = o_mode_sel ? {256'b0, i_decoder_data} : i_encoder_data;
  assign need_in  = in_words(o_mode_sel, o_code_rate);
  assign need_out = out_words(o_mode_sel, o_code_rate);
  assign o_busy   = (state != IDLE);

  assign o_encoder_data_frame = in_q[127:0];
  assign o_decoder_data_frame = o_code_rate ? in_q : {128'b0, in_q[255:0]};

  // Word 0 bulk-loads the frame zero-extended so a shorter frame never inherits stale upper words.
  endec_word_shifter u_in_frame (
    .clk       (sys_clk),
    .rst       (rst),
    .load_en   ((state == IDLE) && s_fire),
    .load_data (FRAME_W'(i_s_data)),
    .wr_en     ((state == LOAD) && s_fire),
    .wr_idx    (cnt),
    .wr_word   (i_s_data),
    .rd_idx    (cnt),
    .q         (in_q),
    .rd_word   (unused_in_word)
  );

  // Read index runs one ahead so o_m_data can register the next word on each accept.
  endec_word_shifter u_out_frame (
    .clk       (sys_clk),
    .rst       (rst),
    .load_en   ((state == RUN) && done_hit),
    .load_data (result),
    .wr_en     (1'b0),
    .wr_idx    (4'd0),
    .wr_word   ('0),
    .rd_idx    (cnt + 4'd1),
    .q         (unused_out_q),
    .rd_word   (out_word)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      tmr          <= '0;
      o_s_ready    <= 1'b0;
      o_m_valid    <= 1'b0;
      o_m_data     <= '0;
      o_en         <= 1'b0;
      o_timeout    <= 1'b0;
      o_code_rate  <= 1'b0;
      o_constr_len <= 1'b0;
      o_mode_sel   <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          o_s_ready <= 1'b1;
          if (s_fire) begin
            o_code_rate  <= i_code_rate;
            o_constr_len <= i_constr_len;
            o_mode_sel   <= i_mode_sel;
            cnt          <= 4'd1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (s_fire) begin
            if (cnt == need_in - 4'd1) begin
              cnt       <= '0;
              tmr       <= '0;
              o_s_ready <= 1'b0;
              o_en      <= 1'b1;
              state     <= RUN;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        RUN: begin
          // A done on the final allowed cycle still wins over the timeout.
          if (done_hit) begin
            o_en      <= 1'b0;
            o_m_valid <= 1'b1;
            o_m_data  <= result[WORD_W-1:0];
            cnt       <= '0;
            state     <= UNLOAD;
          end else if (tmr == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            o_en      <= 1'b0;
            o_timeout <= 1'b1;
            o_s_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        UNLOAD: begin
          if (m_fire) begin
            if (cnt == need_out - 4'd1) begin
              o_m_valid <= 1'b0;
              o_s_ready <= 1'b1;
              cnt       <= '0;
              state     <= IDLE;
            end else begin
              cnt      <= cnt + 4'd1;
              o_m_data <= out_word;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_endec_host_adapter.sv
// Directed-sequence bench with randomized payloads, checked against a frame/word-list model of the adapter.
// Drives and samples on the falling edge; the DUT acts on the rising edge.
module tb_endec_host_adapter;

  localparam int TO = 4096;

  logic         sys_clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_code_rate = 1'b0, i_constr_len = 1'b0, i_mode_sel = 1'b0;
  logic [31:0]  i_s_data = '0;
  logic         i_s_valid = 1'b0;
  logic         o_s_ready;
  logic [31:0]  o_m_data;
  logic         o_m_valid;
  logic         i_m_ready = 1'b0;
  logic         o_en, o_code_rate, o_constr_len, o_mode_sel;
  logic [127:0] o_encoder_data_frame;
  logic [383:0] o_decoder_data_frame;
  logic [383:0] i_encoder_data = '0;
  logic         i_encoder_done = 1'b0;
  logic [127:0] i_decoder_data = '0;
  logic         i_decoder_done = 1'b0;
  logic         o_busy, o_timeout;

  int ncmp = 0;
  int nfail = 0;
  logic exp_mode, exp_rate, exp_cl;

  endec_host_adapter #(.TIMEOUT_CYCLES(TO), .CNT_W(13)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .i_code_rate(i_code_rate), .i_constr_len(i_constr_len), .i_mode_sel(i_mode_sel),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .o_en(o_en), .o_code_rate(o_code_rate), .o_constr_len(o_constr_len), .o_mode_sel(o_mode_sel),
    .o_encoder_data_frame(o_encoder_data_frame), .o_decoder_data_frame(o_decoder_data_frame),
    .i_encoder_data(i_encoder_data), .i_encoder_done(i_encoder_done),
    .i_decoder_data(i_decoder_data), .i_decoder_done(i_decoder_done),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: word counts straight from the mode/rate table.
  function automatic int n_in(input logic mode, input logic rate);
    return mode ? (rate ? 12 : 8) : 4;
  endfunction

  function automatic int n_out(input logic mode, input logic rate);
    return mode ? 4 : (rate ? 12 : 8);
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, {o_s_ready, o_m_valid, o_m_data, o_en, o_code_rate, o_constr_len,
                          o_mode_sel, o_busy, o_timeout}, '0);
    check({tag, "_enc_frame"}, o_encoder_data_frame, '0);
    check({tag, "_dec_frame"}, o_decoder_data_frame, '0);
  endtask

  task automatic push_word(input logic [31:0] w);
    int b;
    b = 0;
    i_s_valid = 1'b1;
    i_s_data  = w;
    while (o_s_ready !== 1'b1 && b < 100) begin
      @(negedge sys_clk);
      b++;
    end
    if (b != 0) check("s_ready_wait", o_s_ready, 1);
    @(negedge sys_clk);
    i_s_valid = 1'b0;
    i_s_data  = $urandom;
  endtask

  task automatic send_frame(input logic mode, input logic rate, input logic cl, input logic [31:0] w[12]);
    logic [383:0] f;
    int n;
    n = n_in(mode, rate);
    f = '0;
    for (int k = 0; k < n; k++) f[k*32 +: 32] = w[k];
    exp_mode = mode; exp_rate = rate; exp_cl = cl;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        i_mode_sel = mode; i_code_rate = rate; i_constr_len = cl;
      end else begin
        i_mode_sel = 1'($urandom); i_code_rate = 1'($urandom); i_constr_len = 1'($urandom);
      end
      push_word(w[k]);
    end
    check("load_en_rise", o_en, 1);
    check("load_busy", o_busy, 1);
    check("load_ready_drop", o_s_ready, 0);
    check("load_cfg", {o_mode_sel, o_code_rate, o_constr_len}, {exp_mode, exp_rate, exp_cl});
    if (mode) check("dec_frame", o_decoder_data_frame, f);
    else      check("enc_frame", o_encoder_data_frame, f[127:0]);
  endtask

  task automatic respond(input logic mode, input int delay, input logic [383:0] res, input logic wrong);
    logic [383:0] junk;
    for (int c = 0; c < delay; c++) begin
      for (int k = 0; k < 12; k++) junk[k*32 +: 32] = $urandom;
      i_encoder_data = junk; i_decoder_data = junk[383:256];
      i_mode_sel = 1'($urandom); i_code_rate = 1'($urandom); i_constr_len = 1'($urandom);
      if (wrong && c == 1) begin
        if (mode) i_encoder_done = 1'b1;
        else      i_decoder_done = 1'b1;
      end
      @(negedge sys_clk);
      i_encoder_done = 1'b0; i_decoder_done = 1'b0;
    end
    check("run_en_held", {o_en, o_busy, o_m_valid, o_s_ready}, 4'b1100);
    check("run_cfg_held", {o_mode_sel, o_code_rate, o_constr_len}, {exp_mode, exp_rate, exp_cl});
    if (mode) begin i_decoder_done = 1'b1; i_decoder_data = res[127:0]; end
    else      begin i_encoder_done = 1'b1; i_encoder_data = res; end
    @(negedge sys_clk);
    i_encoder_done = 1'b0; i_decoder_done = 1'b0;
    i_encoder_data = ~res; i_decoder_data = ~res[127:0];
    check("done_en_drop", o_en, 0);
    check("done_m_valid", o_m_valid, 1);
  endtask

  task automatic drain(input logic mode, input logic rate, input logic [383:0] res,
                       input int bp_at, input int bp_len);
    logic [31:0] held;
    logic stable;
    int b;
    for (int k = 0; k < n_out(mode, rate); k++) begin
      if (k == bp_at) begin
        i_m_ready = 1'b0;
        held = o_m_data;
        stable = 1'b1;
        repeat (bp_len) begin
          @(negedge sys_clk);
          if (o_m_data !== held || o_m_valid !== 1'b1) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_cfg_held", o_mode_sel, exp_mode);
      end
      i_m_ready = 1'b1;
      b = 0;
      while (o_m_valid !== 1'b1 && b < 100) begin
        @(negedge sys_clk);
        b++;
      end
      check("out_valid", o_m_valid, 1);
      check("out_word", o_m_data, res[k*32 +: 32]);
      @(negedge sys_clk);
      i_m_ready = 1'b0;
    end
    check("end_idle", {o_busy, o_m_valid, o_s_ready, o_en}, 4'b0010);
  endtask

  initial begin
    logic [31:0]  w[12];
    logic [383:0] res;
    int cyc;
    logic saw_valid;
    logic md, rt;

    repeat (2) @(negedge sys_clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge sys_clk);
    check("idle_ready", {o_s_ready, o_busy}, 2'b10);

    // Encode, rate 1/3, directed words and result.
    for (int k = 0; k < 12; k++) w[k] = 32'h11111111 * (k + 1);
    send_frame(1'b0, 1'b1, 1'b1, w);
    check("enc_frame_directed", o_encoder_data_frame, 128'h44444444_33333333_22222222_11111111);
    res = '0;
    for (int k = 0; k < 12; k++) res[k*32 +: 32] = 32'hA0 + k;
    respond(1'b0, 20, res, 1'b0);
    drain(1'b0, 1'b1, res, -1, 0);

    // Decode, rate 1/2: upper third of the decoder frame must read zero.
    for (int k = 0; k < 12; k++) w[k] = $urandom;
    send_frame(1'b1, 1'b0, 1'b0, w);
    check("dec_r12_upper_zero", o_decoder_data_frame[383:256], '0);
    res = {256'b0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF};
    respond(1'b1, 7, res, 1'b0);
    check("dec_first_lsw", o_m_data, 32'h89ABCDEF);
    drain(1'b1, 1'b0, res, -1, 0);

    // Timeout: done never arrives.
    for (int k = 0; k < 12; k++) w[k] = $urandom;
    send_frame(1'b0, 1'b0, 1'b1, w);
    cyc = 0;
    saw_valid = 1'b0;
    while (o_en === 1'b1 && cyc < TO + 10) begin
      cyc++;
      if (o_m_valid !== 1'b0 || o_timeout !== 1'b0) saw_valid = 1'b1;
      @(negedge sys_clk);
    end
    check("to_run_cycles", cyc, TO);
    check("to_pulse", {o_timeout, o_en, o_busy, o_s_ready, o_m_valid}, 5'b10010);
    @(negedge sys_clk);
    check("to_pulse_end", {o_timeout, o_m_valid}, 2'b00);
    check("to_no_early_flags", saw_valid, 0);

    // Backpressure mid-UNLOAD with config toggling during RUN.
    for (int k = 0; k < 12; k++) w[k] = $urandom;
    send_frame(1'b0, 1'b0, 1'b0, w);
    for (int k = 0; k < 12; k++) res[k*32 +: 32] = $urandom;
    respond(1'b0, 15, res, 1'b0);
    drain(1'b0, 1'b0, res, 3, 50);

    // Wrong done is ignored in encode mode.
    for (int k = 0; k < 12; k++) w[k] = $urandom;
    send_frame(1'b0, 1'b1, 1'b0, w);
    for (int k = 0; k < 12; k++) res[k*32 +: 32] = $urandom;
    respond(1'b0, 6, res, 1'b1);
    drain(1'b0, 1'b1, res, 5, 3);

    // Reset in the middle of LOAD, then a clean decode rate 1/3 frame.
    i_mode_sel = 1'b1; i_code_rate = 1'b1; i_constr_len = 1'b1;
    push_word(32'hFFFF0000);
    push_word(32'h0000FFFF);
    #1 rst = 1'b1;
    #1 check_reset_state("midload_reset");
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    for (int k = 0; k < 12; k++) w[k] = $urandom;
    send_frame(1'b1, 1'b1, 1'b0, w);
    res = '0;
    for (int k = 0; k < 4; k++) res[k*32 +: 32] = $urandom;
    respond(1'b1, 3, res, 1'b1);
    drain(1'b1, 1'b1, res, 2, 7);

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      md = 1'($urandom);
      rt = 1'($urandom);
      for (int k = 0; k < 12; k++) w[k] = $urandom;
      send_frame(md, rt, 1'($urandom), w);
      res = '0;
      for (int k = 0; k < n_out(md, rt); k++) res[k*32 +: 32] = $urandom;
      respond(md, int'($urandom_range(0, 30)), res, 1'b0);
      drain(md, rt, res, int'($urandom_range(0, 3)), int'($urandom_range(1, 10)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
